dev_capture: RTL and testbench

DEV_CAPTURE -- requirements
Module: dev_capture

---
 rtl/dev_capture_pkg.sv | 40 ++++
 rtl/dev_capture_sync.sv | 63 ++++++
 rtl/dev_capture.sv | 171 +++++++++++++++++
 tb/tb_dev_capture.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dev_capture_pkg.sv
// ============================================================================
// dev_capture_pkg : shared state encoding, register map, clock-source codes
// Revision 1.0 : initial release
// ============================================================================
`default_nettype none

package dev_capture_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ARMED  = 2'd1;
  localparam logic [1:0] ST_PHASE1 = 2'd2;
  localparam logic [1:0] ST_PHASE2 = 2'd3;

  localparam logic [1:0] ADDR_CFG    = 2'd0;
  localparam logic [1:0] ADDR_WIDTH  = 2'd1;
  localparam logic [1:0] ADDR_PERIOD = 2'd2;
  localparam logic [1:0] ADDR_STATUS = 2'd3;

  localparam logic [2:0] SRC_OFF     = 3'd0;
  localparam logic [2:0] SRC_CLK     = 3'd1;
  localparam logic [2:0] SRC_DIV8    = 3'd2;
  localparam logic [2:0] SRC_DIV64   = 3'd3;
  localparam logic [2:0] SRC_DIV256  = 3'd4;
  localparam logic [2:0] SRC_DIV1024 = 3'd5;

  localparam int FILTER_DEPTH = 4;

  typedef struct packed {
    logic       cont;
    logic       pol;
    logic [2:0] clk_source;
  } cfg_t;

  function automatic logic src_valid(input logic [2:0] src);
    return (src >= SRC_CLK) && (src <= SRC_DIV1024);
  endfunction

endpackage

`default_nettype wire

// File: rtl/dev_capture_sync.sv
// ============================================================================
// dev_capture_sync : 2-FF synchronizer, optional glitch filter (CAPTURE_FILTER_EN),
//                    registered rise/fall pulse detector
// Revision 1.0 : initial release
// ============================================================================
`default_nettype none

module dev_capture_sync
  import dev_capture_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic io_in,
  output logic risen,
  output logic fallen
);

  logic sync1;
  logic sync2;
  logic level;
  logic level_prev;

`ifdef CAPTURE_FILTER_EN
  localparam int CW = $clog2(FILTER_DEPTH);
  logic [CW-1:0] stable_cnt;

  // The filtered level follows sync2 only after FILTER_DEPTH consecutive differing samples
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stable_cnt <= '0;
      level      <= 1'b0;
    end else if (sync2 == level) begin
      stable_cnt <= '0;
    end else if (stable_cnt == CW'(FILTER_DEPTH - 1)) begin
      stable_cnt <= '0;
      level      <= sync2;
    end else begin
      stable_cnt <= stable_cnt + 1'b1;
    end
  end
`else
  assign level = sync2;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1      <= 1'b0;
      sync2      <= 1'b0;
      level_prev <= 1'b0;
      risen      <= 1'b0;
      fallen     <= 1'b0;
    end else begin
      sync1      <= io_in;
      sync2      <= sync1;
      level_prev <= level;
      risen      <= level & ~level_prev;
      fallen     <= ~level & level_prev;
    end
  end

endmodule

`default_nettype wire

// File: rtl/dev_capture.sv
// ============================================================================
// dev_capture : pulse width / period capture timer with prescaler and bus regs
//               (optional input glitch filter via CAPTURE_FILTER_EN)
// Revision 1.0 : initial release
// ============================================================================
`default_nettype none

module dev_capture
  import dev_capture_pkg::*;
#(
  parameter int CAPTURE_BITS = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        io_in,
  output logic        int_capture,
  output logic        int_ovf,
  input  logic        we,
  input  logic        stb,
  input  logic [1:0]  addr,
  input  logic [31:0] dtw,
  output logic [31:0] dtr,
  output logic        ack
);

  cfg_t                    cfg;
  logic [CAPTURE_BITS-1:0] width;
  logic [CAPTURE_BITS-1:0] period;
  logic [CAPTURE_BITS-1:0] counter;
  logic [CAPTURE_BITS-1:0] cap_val;
  logic [9:0]              div;
  logic [1:0]              state;
  logic                    done;
  logic                    ovf;
  logic                    risen;
  logic                    fallen;
  logic                    wr;
  logic                    cfg_wr;
  logic                    status_wr;
  logic                    tick;
  logic                    start_edge;
  logic                    stop_edge;
  logic                    sat;
  logic                    unused_dtw_bits;

  dev_capture_sync u_sync (
    .clk    (clk),
    .reset  (reset),
    .io_in  (io_in),
    .risen  (risen),
    .fallen (fallen)
  );

  assign ack             = 1'b1;
  assign unused_dtw_bits = ^dtw[31:5];
  assign wr              = we && stb;
  assign cfg_wr          = wr && (addr == ADDR_CFG);
  assign status_wr       = wr && (addr == ADDR_STATUS);

  // Edges coinciding with any bus write are dropped
  assign start_edge = !wr && (cfg.pol ? fallen : risen);
  assign stop_edge  = !wr && (cfg.pol ? risen : fallen);
  assign sat        = &counter;
  assign cap_val    = counter + CAPTURE_BITS'(tick);

  always_comb begin
    tick = 1'b0;
    case (cfg.clk_source)
      SRC_CLK:     tick = 1'b1;
      SRC_DIV8:    tick = (div[2:0] == 3'h7);
      SRC_DIV64:   tick = (div[5:0] == 6'h3F);
      SRC_DIV256:  tick = (div[7:0] == 8'hFF);
      SRC_DIV1024: tick = (div == 10'h3FF);
      default:     tick = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div <= '0;
    end else if (cfg_wr) begin
      div <= '0;
    end else begin
      div <= div + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cfg         <= '0;
      width       <= '0;
      period      <= '0;
      counter     <= '0;
      done        <= 1'b0;
      ovf         <= 1'b0;
      state       <= ST_IDLE;
      int_capture <= 1'b0;
      int_ovf     <= 1'b0;
    end else begin
      int_capture <= 1'b0;
      int_ovf     <= 1'b0;
      if (cfg_wr) begin
        cfg   <= cfg_t'(dtw[4:0]);
        done  <= 1'b0;
        state <= src_valid(dtw[2:0]) ? ST_ARMED : ST_IDLE;
      end else begin
        if (status_wr) begin
          if (dtw[2]) done <= 1'b0;
          if (dtw[3]) ovf  <= 1'b0;
        end
        case (state)
          ST_IDLE: ;
          ST_ARMED: begin
            if (start_edge) begin
              counter <= '0;
              state   <= ST_PHASE1;
            end
          end
          ST_PHASE1: begin
            if (sat && tick) begin
              ovf     <= 1'b1;
              int_ovf <= 1'b1;
              state   <= ST_IDLE;
            end else begin
              if (tick) counter <= counter + 1'b1;
              if (stop_edge) begin
                width <= cap_val;
                state <= ST_PHASE2;
              end
            end
          end
          ST_PHASE2: begin
            if (sat && tick) begin
              ovf     <= 1'b1;
              int_ovf <= 1'b1;
              state   <= ST_IDLE;
            end else if (start_edge) begin
              period      <= cap_val;
              done        <= 1'b1;
              int_capture <= 1'b1;
              // Continuous mode restarts immediately so no period is lost
              if (cfg.cont) begin
                counter <= '0;
                state   <= ST_PHASE1;
              end else begin
                state <= ST_IDLE;
              end
            end else if (tick) begin
              counter <= counter + 1'b1;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  always_comb begin
    dtr = 32'd0;
    case (addr)
      ADDR_CFG:    dtr = {27'd0, cfg};
      ADDR_WIDTH:  dtr = 32'(width);
      ADDR_PERIOD: dtr = 32'(period);
      ADDR_STATUS: dtr = {28'd0, ovf, done, state};
      default:     dtr = 32'd0;
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_dev_capture.sv
// ============================================================================
// tb_dev_capture : scoreboard bench for dev_capture (16-bit and 8-bit instances)
// Revision 1.0 : initial release
// ============================================================================
`default_nettype none

module tb_dev_capture;

  logic        clk   = 1'b0;
  logic        reset = 1'b0;
  logic        io_in = 1'b0;
  logic        we    = 1'b0;
  logic        stb   = 1'b0;
  logic [1:0]  addr  = 2'd0;
  logic [31:0] dtw   = 32'd0;
  logic [31:0] dtr, dtr8;
  logic        int_capture, int_ovf, ack;
  logic        int_capture8, int_ovf8, ack8;

  always #5 clk = ~clk;

  dev_capture #(.CAPTURE_BITS(16)) dut (
    .clk(clk), .reset(reset), .io_in(io_in), .int_capture(int_capture), .int_ovf(int_ovf),
    .we(we), .stb(stb), .addr(addr), .dtw(dtw), .dtr(dtr), .ack(ack)
  );

  dev_capture #(.CAPTURE_BITS(8)) dut8 (
    .clk(clk), .reset(reset), .io_in(io_in), .int_capture(int_capture8), .int_ovf(int_ovf8),
    .we(we), .stb(stb), .addr(addr), .dtw(dtw), .dtr(dtr8), .ack(ack8)
  );

  typedef struct {
    int w_lo;
    int w_hi;
    int p_lo;
    int p_hi;
  } exp_t;

  exp_t sb[$];
  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int cap_pulses = 0;
  int ovf_pulses = 0;
  int ovf8_pulses = 0;
  int ovf8_cycle = 0;

  always @(negedge clk) begin
    cyc++;
    if (int_capture) cap_pulses++;
    if (int_ovf) ovf_pulses++;
    if (int_ovf8) begin
      ovf8_pulses++;
      ovf8_cycle = cyc;
    end
  end

  task automatic do_reset();
    io_in = 1'b0; we = 1'b0; stb = 1'b0; addr = 2'd0; dtw = 32'd0;
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    we = 1'b1; stb = 1'b1; addr = a; dtw = d;
    @(negedge clk);
    we = 1'b0; stb = 1'b0; dtw = 32'd0;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [31:0] d, output logic [31:0] d8);
    addr = a;
    #1;
    d  = dtr;
    d8 = dtr8;
  endtask

  task automatic hold(input logic v, input int n);
    io_in = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_capture(input int budget, input string name, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if (int_capture) seen = 1'b1;
    end
    if (!seen) begin
      n_cmp++; n_bad++;
      $display("FAIL %s_timeout: int_capture got 0 want 1 within %0d clk", name, budget);
    end
  endtask

  task automatic test_reset();
    logic [31:0] d, d8;
    repeat (2) @(negedge clk);
    for (int a = 0; a < 4; a++) begin
      bus_read(a[1:0], d, d8);
      n_cmp++;
      if (d !== 32'd0) begin
        n_bad++; $display("FAIL reset_reg%0d: got %0h want 0", a, d);
      end
    end
    n_cmp++;
    if ({int_capture, int_ovf} !== 2'b00) begin
      n_bad++; $display("FAIL reset_irq: got %b want 00", {int_capture, int_ovf});
    end
    n_cmp++;
    if (ack !== 1'b1) begin
      n_bad++; $display("FAIL reset_ack: got %b want 1", ack);
    end
  endtask

  task automatic test_single_high();
    logic [31:0] w, p, s, x;
    bit seen;
    int c0;
    exp_t e;
    do_reset();
    bus_write(2'd0, 32'h01);
    sb.push_back('{20, 20, 50, 50});
    c0 = cap_pulses;
    hold(1'b1, 20);
    hold(1'b0, 30);
    io_in = 1'b1;
    wait_capture(40, "s1", seen);
    e = sb.pop_front();
    if (seen) begin
      bus_read(2'd1, w, x); bus_read(2'd2, p, x); bus_read(2'd3, s, x);
      n_cmp++;
      if (w !== 32'(e.w_lo)) begin n_bad++; $display("FAIL s1_width: got %0d want %0d", w, e.w_lo); end
      n_cmp++;
      if (p !== 32'(e.p_lo)) begin n_bad++; $display("FAIL s1_period: got %0d want %0d", p, e.p_lo); end
      n_cmp++;
      if (s !== 32'h4) begin n_bad++; $display("FAIL s1_status: got %0h want 4", s); end
    end
    repeat (10) @(negedge clk);
    n_cmp++;
    if (cap_pulses - c0 !== 1) begin
      n_bad++; $display("FAIL s1_pulses: got %0d want 1", cap_pulses - c0);
    end
  endtask

  task automatic test_low_phase();
    logic [31:0] w, p, s, x;
    bit seen;
    exp_t e;
    do_reset();
    bus_write(2'd0, 32'h09);
    sb.push_back('{12, 12, 20, 20});
    hold(1'b1, 10);
    hold(1'b0, 12);
    hold(1'b1, 8);
    io_in = 1'b0;
    wait_capture(40, "s2", seen);
    e = sb.pop_front();
    if (seen) begin
      bus_read(2'd1, w, x); bus_read(2'd2, p, x); bus_read(2'd3, s, x);
      n_cmp++;
      if (w !== 32'(e.w_lo)) begin n_bad++; $display("FAIL s2_width: got %0d want %0d", w, e.w_lo); end
      n_cmp++;
      if (p !== 32'(e.p_lo)) begin n_bad++; $display("FAIL s2_period: got %0d want %0d", p, e.p_lo); end
      n_cmp++;
      if (s !== 32'h4) begin n_bad++; $display("FAIL s2_status: got %0h want 4", s); end
    end
  endtask

  task automatic test_back_to_back();
    int c0;
    do_reset();
    bus_write(2'd0, 32'h11);
    for (int k = 0; k < 3; k++) sb.push_back('{5, 5, 10, 10});
    c0 = cap_pulses;
    fork
      begin
        for (int k = 0; k < 3; k++) begin
          hold(1'b1, 5);
          hold(1'b0, 5);
        end
        io_in = 1'b1;
      end
      begin
        logic [31:0] w, p, s, x;
        bit seen;
        exp_t e;
        for (int k = 0; k < 3; k++) begin
          wait_capture(60, "s3", seen);
          e = sb.pop_front();
          if (seen) begin
            bus_read(2'd1, w, x); bus_read(2'd2, p, x);
            n_cmp++;
            if (w !== 32'(e.w_lo)) begin n_bad++; $display("FAIL s3_width%0d: got %0d want %0d", k, w, e.w_lo); end
            n_cmp++;
            if (p !== 32'(e.p_lo)) begin n_bad++; $display("FAIL s3_period%0d: got %0d want %0d", k, p, e.p_lo); end
          end
        end
        bus_read(2'd3, s, x);
        n_cmp++;
        if (s !== 32'h6) begin n_bad++; $display("FAIL s3_status: got %0h want 6", s); end
      end
    join
    repeat (20) @(negedge clk);
    n_cmp++;
    if (cap_pulses - c0 !== 3) begin
      n_bad++; $display("FAIL s3_pulses: got %0d want 3", cap_pulses - c0);
    end
  endtask

  task automatic test_overflow();
    logic [31:0] d, d8;
    int c0, c16, t0;
    do_reset();
    bus_write(2'd0, 32'h01);
    c0  = ovf8_pulses;
    c16 = ovf_pulses;
    t0  = cyc;
    hold(1'b1, 300);
    n_cmp++;
    if (ovf8_pulses - c0 !== 1) begin
      n_bad++; $display("FAIL s4_ovf_pulses: got %0d want 1", ovf8_pulses - c0);
    end
    n_cmp++;
    if (ovf8_cycle - t0 < 250 || ovf8_cycle - t0 > 270) begin
      n_bad++; $display("FAIL s4_ovf_time: got %0d want 250..270", ovf8_cycle - t0);
    end
    n_cmp++;
    if (ovf_pulses - c16 !== 0) begin
      n_bad++; $display("FAIL s4_ovf16_pulses: got %0d want 0", ovf_pulses - c16);
    end
    bus_read(2'd3, d, d8);
    n_cmp++;
    if (d8 !== 32'h8) begin n_bad++; $display("FAIL s4_status: got %0h want 8", d8); end
    bus_read(2'd1, d, d8);
    n_cmp++;
    if (d8 !== 32'h0) begin n_bad++; $display("FAIL s4_width: got %0d want 0", d8); end
    bus_write(2'd3, 32'h8);
    bus_read(2'd3, d, d8);
    n_cmp++;
    if (d8 !== 32'h0) begin n_bad++; $display("FAIL s4_ovf_clear: got %0h want 0", d8); end
  endtask

  task automatic test_prescaler();
    logic [31:0] w, p, x;
    bit seen;
    exp_t e;
    do_reset();
    bus_write(2'd0, 32'h02);
    sb.push_back('{9, 11, 19, 21});
    hold(1'b1, 80);
    hold(1'b0, 80);
    io_in = 1'b1;
    wait_capture(60, "s5", seen);
    e = sb.pop_front();
    if (seen) begin
      bus_read(2'd1, w, x); bus_read(2'd2, p, x);
      n_cmp++;
      if (w < 32'(e.w_lo) || w > 32'(e.w_hi)) begin
        n_bad++; $display("FAIL s5_width: got %0d want %0d..%0d", w, e.w_lo, e.w_hi);
      end
      n_cmp++;
      if (p < 32'(e.p_lo) || p > 32'(e.p_hi)) begin
        n_bad++; $display("FAIL s5_period: got %0d want %0d..%0d", p, e.p_lo, e.p_hi);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] d, d8;
    int c0, o0;
    do_reset();
    bus_write(2'd0, 32'h01);
    c0 = cap_pulses;
    o0 = ovf_pulses;
    hold(1'b1, 10);
    bus_read(2'd3, d, d8);
    n_cmp++;
    if (d !== 32'h2) begin n_bad++; $display("FAIL s6_phase1: got %0h want 2", d); end
    #3;
    reset = 1'b0;
    for (int a = 0; a < 4; a++) begin
      bus_read(a[1:0], d, d8);
      n_cmp++;
      if (d !== 32'd0) begin n_bad++; $display("FAIL s6_reg%0d: got %0h want 0", a, d); end
    end
    hold(1'b0, 3);
    reset = 1'b1;
    hold(1'b0, 10);
    hold(1'b1, 10);
    hold(1'b0, 10);
    n_cmp++;
    if ((cap_pulses - c0) + (ovf_pulses - o0) !== 0) begin
      n_bad++; $display("FAIL s6_irq: got %0d pulses want 0", (cap_pulses - c0) + (ovf_pulses - o0));
    end
`ifdef CAPTURE_FILTER_EN
    do_reset();
    bus_write(2'd0, 32'h01);
    hold(1'b1, 2);
    hold(1'b0, 20);
    bus_read(2'd3, d, d8);
    n_cmp++;
    if (d !== 32'h1) begin n_bad++; $display("FAIL s6_glitch: got %0h want 1", d); end
`endif
  endtask

  initial begin
    test_reset();
    test_single_high();
    test_low_phase();
    test_back_to_back();
    test_overflow();
    test_prescaler();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
